// File: rtl/bht_branch_predictor_pkg.sv
// Shared types and defaults for the branch history table.
// The counter encodings and the default reset value are also used by decode/execute.
package bht_branch_predictor_pkg;

  typedef enum logic [1:0] {
    CTR_STRONG_NT = 2'b00,
    CTR_WEAK_NT   = 2'b01,
    CTR_WEAK_T    = 2'b10,
    CTR_STRONG_T  = 2'b11
  } ctr2_e;

  typedef enum logic [1:0] {
    CTR_HOLD = 2'b00,
    CTR_INC  = 2'b01,
    CTR_DEC  = 2'b10
  } ctr_op_e;

  localparam int unsigned XLEN_DEFAULT      = 32;
  localparam int unsigned ENTRIES_DEFAULT   = 64;
  localparam int unsigned CTR_BITS_DEFAULT  = 2;
  localparam logic [1:0]  RESET_CTR_DEFAULT = CTR_WEAK_T;

endpackage

// File: rtl/bht_branch_predictor_if.sv
// Fetch lookup, execute resolution and perf-counter signals of the predictor.
// master = pipeline side, slave = predictor.
interface bht_branch_predictor_if
  import bht_branch_predictor_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_imm;
  logic            f_is_branch;
  logic            f_taken;
  logic [XLEN-1:0] f_next_pc;
  logic            e_valid;
  logic [XLEN-1:0] e_pc;
  logic [XLEN-1:0] e_target;
  logic            e_taken;
  logic            e_pred_taken;
  logic            flush;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     mispred_cnt;

  modport master (
    output f_pc, f_imm, f_is_branch, e_valid, e_pc, e_target, e_taken, e_pred_taken,
    input  f_taken, f_next_pc, flush, redirect_pc, mispred_cnt
  );

  modport slave (
    input  f_pc, f_imm, f_is_branch, e_valid, e_pc, e_target, e_taken, e_pred_taken,
    output f_taken, f_next_pc, flush, redirect_pc, mispred_cnt
  );
endinterface

// File: rtl/bht_branch_predictor_sat_counter.sv
// One saturating up/down prediction counter; reset wins over any pending update.
module bht_sat_counter
  import bht_branch_predictor_pkg::*;
#(
  parameter int unsigned          CTR_BITS  = CTR_BITS_DEFAULT,
  parameter logic [CTR_BITS-1:0]  RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  ctr_op_e             op_i,
  output logic [CTR_BITS-1:0] ctr_o
);
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

  logic [CTR_BITS-1:0] ctr_q;
  logic [CTR_BITS-1:0] ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    case (op_i)
      CTR_INC: if (ctr_q != CTR_MAX) ctr_d = ctr_q + CTR_BITS'(1);
      CTR_DEC: if (ctr_q != '0)      ctr_d = ctr_q - CTR_BITS'(1);
      default: ctr_d = ctr_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) ctr_q <= RESET_VAL;
    else     ctr_q <= ctr_d;
  end

  assign ctr_o = ctr_q;
endmodule

// File: rtl/bht_branch_predictor.sv
// Untagged PC-indexed branch history table with combinational lookup,
// one resolved update per cycle, mispredict flush/redirect and a saturating mispredict counter.
module bht_branch_predictor
  import bht_branch_predictor_pkg::*;
#(
  parameter int unsigned         XLEN      = XLEN_DEFAULT,
  parameter int unsigned         ENTRIES   = ENTRIES_DEFAULT,
  parameter int unsigned         CTR_BITS  = CTR_BITS_DEFAULT,
  parameter logic [CTR_BITS-1:0] RESET_CTR = CTR_BITS'(RESET_CTR_DEFAULT)
) (
  input  logic                 clk,
  input  logic                 rst,
  bht_branch_predictor_if.slave bus
);
  localparam int unsigned IDX_BITS = $clog2(ENTRIES);

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] e_idx;
  logic [CTR_BITS-1:0] ctr_val [ENTRIES];
  logic [CTR_BITS-1:0] rd_ctr;
  logic                f_taken;
  logic                flush;
  logic [31:0]         cnt_q;
  logic [31:0]         cnt_d;

  // Word-aligned PCs: bits [1:0] never select an entry, upper bits alias.
  assign f_idx = bus.f_pc[IDX_BITS+1:2];
  assign e_idx = bus.e_pc[IDX_BITS+1:2];

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
    ctr_op_e op;

    always_comb begin
      op = CTR_HOLD;
      if (bus.e_valid && (e_idx == IDX_BITS'(gi)))
        op = bus.e_taken ? CTR_INC : CTR_DEC;
    end

    bht_sat_counter #(
      .CTR_BITS  (CTR_BITS),
      .RESET_VAL (RESET_CTR)
    ) u_ctr (
      .clk   (clk),
      .rst   (rst),
      .op_i  (op),
      .ctr_o (ctr_val[gi])
    );
  end

  // No bypass: a same-cycle update to f_idx is seen by the next lookup only.
  assign rd_ctr        = rst ? RESET_CTR : ctr_val[f_idx];
  assign f_taken       = bus.f_is_branch & rd_ctr[CTR_BITS-1];
  assign bus.f_taken   = f_taken;
  assign bus.f_next_pc = f_taken ? (bus.f_pc + bus.f_imm) : (bus.f_pc + XLEN'(4));

  assign flush           = bus.e_valid & ~rst & (bus.e_taken != bus.e_pred_taken);
  assign bus.flush       = flush;
  assign bus.redirect_pc = bus.e_taken ? bus.e_target : (bus.e_pc + XLEN'(4));

  always_comb begin
    cnt_d = cnt_q;
    if (flush && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 32'd0;
    else     cnt_q <= cnt_d;
  end

  assign bus.mispred_cnt = cnt_q;
endmodule

// File: tb/tb_bht_branch_predictor.sv
// Directed and randomized check of bht_branch_predictor against a table-of-integers model.
module tb_bht_branch_predictor;
  localparam int NENT = 64;
  localparam int CMAX = 3;
  localparam int RST_CTR = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bht_branch_predictor_if #(.XLEN(32)) bus ();

  bht_branch_predictor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          model_ctr [NENT];
  int unsigned model_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          cmp_en   = 1'b0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % NENT);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state advance, using the inputs the DUT sampled at this edge.
  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < NENT; i++) model_ctr[i] = RST_CTR;
      model_cnt = 0;
    end else if (bus.e_valid) begin
      int k;
      k = idx_of(bus.e_pc);
      if (bus.e_taken) model_ctr[k] = (model_ctr[k] >= CMAX) ? CMAX : model_ctr[k] + 1;
      else             model_ctr[k] = (model_ctr[k] <= 0) ? 0 : model_ctr[k] - 1;
      if (bus.e_taken != bus.e_pred_taken && model_cnt != 32'hFFFF_FFFF) model_cnt++;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      int          c;
      logic        exp_taken;
      logic        exp_flush;
      logic [31:0] exp_next;
      logic [31:0] exp_redir;
      c         = rst ? RST_CTR : model_ctr[idx_of(bus.f_pc)];
      exp_taken = bus.f_is_branch && (c >= 2);
      exp_next  = exp_taken ? bus.f_pc + bus.f_imm : bus.f_pc + 32'd4;
      exp_flush = bus.e_valid && !rst && (bus.e_taken != bus.e_pred_taken);
      check("f_taken", {31'd0, bus.f_taken}, {31'd0, exp_taken});
      check("f_next_pc", bus.f_next_pc, exp_next);
      check("flush", {31'd0, bus.flush}, {31'd0, exp_flush});
      if (exp_flush) begin
        exp_redir = bus.e_taken ? bus.e_target : bus.e_pc + 32'd4;
        check("redirect_pc", bus.redirect_pc, exp_redir);
      end
      check("mispred_cnt", bus.mispred_cnt, model_cnt);
    end
  end

  task automatic apply(input logic r, input logic [31:0] fpc, input logic [31:0] fimm,
                       input logic fbr, input logic ev, input logic [31:0] epc,
                       input logic [31:0] etgt, input logic etk, input logic epred);
    rst              = r;
    bus.f_pc         = fpc;
    bus.f_imm        = fimm;
    bus.f_is_branch  = fbr;
    bus.e_valid      = ev;
    bus.e_pc         = epc;
    bus.e_target     = etgt;
    bus.e_taken      = etk;
    bus.e_pred_taken = epred;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic [31:0] imm);
    apply(1'b0, pc, imm, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < NENT; i++) model_ctr[i] = 0;
    model_cnt = 0;

    // Reset; lookup during reset must already see the reset counter value.
    apply(1'b1, 32'h100, 32'h20, 1'b1, 1'b1, 32'h100, 32'h0, 1'b1, 1'b0);
    check("rst_f_taken", {31'd0, bus.f_taken}, 32'd1);
    check("rst_f_next_pc", bus.f_next_pc, 32'h120);
    check("rst_flush", {31'd0, bus.flush}, 32'd0);
    tick();
    cmp_en = 1'b1;

    lookup(32'h100, 32'h20);
    check("t1_f_taken", {31'd0, bus.f_taken}, 32'd1);
    check("t1_f_next_pc", bus.f_next_pc, 32'h120);
    check("t1_cnt", bus.mispred_cnt, 32'd0);
    tick();

    // Two not-taken updates drop 10 -> 00; a third stays at 00.
    repeat (2) begin
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
      tick();
    end
    lookup(32'h100, 32'h20);
    check("t2_f_taken", {31'd0, bus.f_taken}, 32'd0);
    check("t2_f_next_pc", bus.f_next_pc, 32'h104);
    tick();
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 32'h200, 1'b0, 1'b0);
    tick();
    check("t2_model_ctr", model_ctr[idx_of(32'h100)], 32'd0);

    // Hysteresis: saturate at 11, one not-taken leaves it predicting taken.
    repeat (4) begin
      apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h80, 1'b1, 1'b1);
      tick();
    end
    check("t3_model_sat", model_ctr[idx_of(32'h40)], 32'd3);
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40, 32'h80, 1'b0, 1'b0);
    tick();
    check("t3_model_ctr", model_ctr[idx_of(32'h40)], 32'd2);
    lookup(32'h40, 32'h10);
    check("t3_f_taken", {31'd0, bus.f_taken}, 32'd1);
    check("t3_f_next_pc", bus.f_next_pc, 32'h50);
    tick();

    // Aliasing: 0x200 shares an entry with 0x100; 0x104 is a different entry.
    lookup(32'h200, 32'h8);
    check("t4_alias_taken", {31'd0, bus.f_taken}, 32'd0);
    check("t4_alias_next", bus.f_next_pc, 32'h204);
    tick();
    lookup(32'h104, 32'h8);
    check("t4_other_taken", {31'd0, bus.f_taken}, 32'd1);
    check("t4_other_next", bus.f_next_pc, 32'h10c);
    tick();

    // Mispredict flush and redirect, both directions.
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h40, 1'b1, 1'b0);
    check("t5_flush", {31'd0, bus.flush}, 32'd1);
    check("t5_redirect", bus.redirect_pc, 32'h40);
    tick();
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h40, 1'b1, 1'b1);
    check("t5_no_flush", {31'd0, bus.flush}, 32'd0);
    check("t5_cnt1", bus.mispred_cnt, 32'd1);
    tick();
    apply(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h80, 32'h40, 1'b0, 1'b1);
    check("t5_nt_redirect", bus.redirect_pc, 32'h84);
    tick();
    lookup(32'h0, 32'h0);
    check("t5_cnt2", bus.mispred_cnt, 32'd2);
    tick();

    // Same-cycle lookup and update of one entry sees the old value.
    apply(1'b0, 32'h40, 32'h10, 1'b1, 1'b1, 32'h40, 32'h0, 1'b0, 1'b0);
    check("t6_old_value", {31'd0, bus.f_taken}, 32'd1);
    tick();
    lookup(32'h40, 32'h10);
    check("t6_new_value", {31'd0, bus.f_taken}, 32'd0);
    tick();

    // Reset overrides a concurrent mispredicting update.
    apply(1'b1, 32'h40, 32'h10, 1'b1, 1'b1, 32'h40, 32'h0, 1'b1, 1'b0);
    check("t6_rst_flush", {31'd0, bus.flush}, 32'd0);
    check("t6_rst_taken", {31'd0, bus.f_taken}, 32'd1);
    tick();
    lookup(32'h40, 32'h10);
    check("t6_post_rst_taken", {31'd0, bus.f_taken}, 32'd1);
    check("t6_post_rst_cnt", bus.mispred_cnt, 32'd0);
    check("t6_model_ctr", model_ctr[idx_of(32'h40)], 32'd2);
    tick();

    // Randomized traffic over a PC range that wraps the table several times.
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) < 2),
            32'($urandom_range(0, 255)) << 2, $urandom(), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0), 32'($urandom_range(0, 255)) << 2, $urandom(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
